div_sched: RTL

DIV_SCHED -- requirements
Module: div_sched

---
 rtl/div_sched_pkg.sv | 20 ++
 rtl/rr_arb.sv | 37 +++
 rtl/div_sched.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// Shared types and defaults for the divider request scheduler.
package div_sched_pkg;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_BW_DEND = 4;
  localparam int unsigned DEF_BW_DSOR = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter: the requester just after last_i has highest priority.
module rr_arb
  import div_sched_pkg::*;
#(
  parameter int unsigned N  = DEF_N_REQ,
  parameter int unsigned PW = idx_width(DEF_N_REQ)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] last_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0] gnt_hi;
  logic [N-1:0] gnt_lo;
  logic         hit_hi;
  logic         hit_lo;

  // Lowest requester above last_i wins; otherwise wrap to the lowest overall.
  always_comb begin
    gnt_hi = '0;
    gnt_lo = '0;
    hit_hi = 1'b0;
    hit_lo = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (req_i[j] && (PW'(j) > last_i) && !hit_hi) begin
        gnt_hi[j] = 1'b1;
        hit_hi    = 1'b1;
      end
      if (req_i[j] && !hit_lo) begin
        gnt_lo[j] = 1'b1;
        hit_lo    = 1'b1;
      end
    end
    gnt_o = hit_hi ? gnt_hi : gnt_lo;
  end

endmodule

// File: rtl/div_sched.sv
// Shares one external serial divider among N_REQ requesters, one op at a time.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned BW_DEND = DEF_BW_DEND,
  parameter int unsigned BW_DSOR = DEF_BW_DSOR
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CLR,
  input  logic [N_REQ-1:0]           REQ,
  input  logic [N_REQ*BW_DEND-1:0]   DIVIDEND,
  input  logic [N_REQ*BW_DSOR-1:0]   DIVISOR,
  output logic [N_REQ-1:0]           GNT,
  output logic [N_REQ-1:0]           DONE,
  output logic [BW_DEND-1:0]         QUOT,
  output logic [BW_DSOR-1:0]         REM,
  output logic                       DZ,
  output logic                       ERR,
  output logic                       DIV_START,
  output logic [BW_DEND-1:0]         DIV_DIVIDEND,
  output logic [BW_DSOR-1:0]         DIV_DIVISOR,
  input  logic                       DIV_BUSY,
  input  logic [BW_DEND-1:0]         DIV_QUOT,
  input  logic [BW_DSOR-1:0]         DIV_REM
);

  localparam int unsigned    IW         = idx_width(N_REQ);
  localparam int unsigned    CW         = idx_width(BW_DEND + 1);
  localparam logic [CW-1:0]  WAIT_LIMIT = CW'(BW_DEND);
  localparam logic [IW-1:0]  LAST_RST   = IW'(N_REQ - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        last_q,  last_d;
  logic [IW-1:0]        idx_q,   idx_d;
  logic [BW_DEND-1:0]   dend_q,  dend_d;
  logic [BW_DSOR-1:0]   dsor_q,  dsor_d;
  logic [BW_DEND-1:0]   quot_q,  quot_d;
  logic [BW_DSOR-1:0]   rem_q,   rem_d;
  logic                 dz_q,    dz_d;
  logic                 err_q,   err_d;
  logic [CW-1:0]        wcnt_q,  wcnt_d;

  logic [N_REQ-1:0]     arb_gnt;
  logic [IW-1:0]        sel_idx;
  logic [BW_DEND-1:0]   sel_dend;
  logic [BW_DSOR-1:0]   sel_dsor;
  logic                 go;

  rr_arb #(
    .N  (N_REQ),
    .PW (IW)
  ) u_arb (
    .req_i  (REQ),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Neither reset nor abort may let a pulse escape in the same cycle.
  assign go = !RST && !CLR;

  // Pick the winning requester's index and operand slices.
  always_comb begin
    sel_idx  = '0;
    sel_dend = '0;
    sel_dsor = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (arb_gnt[j]) begin
        sel_idx  = IW'(j);
        sel_dend = DIVIDEND[j*BW_DEND +: BW_DEND];
        sel_dsor = DIVISOR[j*BW_DSOR +: BW_DSOR];
      end
    end
  end

  // Decode the state-driven pulses toward requesters and the divider.
  always_comb begin
    GNT       = (state_q == S_IDLE && go) ? arb_gnt : '0;
    DIV_START = (state_q == S_ISSUE) && go;
    DONE      = '0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      DONE[j] = (state_q == S_RESP) && go && (idx_q == IW'(j));
    end
  end

  assign DIV_DIVIDEND = dend_q;
  assign DIV_DIVISOR  = dsor_q;
  assign QUOT         = quot_q;
  assign REM          = rem_q;
  assign DZ           = dz_q;
  assign ERR          = err_q;

  // Next-state and datapath updates; CLR keeps every held value and only drops to IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    idx_d   = idx_q;
    dend_d  = dend_q;
    dsor_d  = dsor_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    err_d   = err_q;
    wcnt_d  = wcnt_q;

    if (CLR) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          wcnt_d = '0;
          if (|REQ) begin
            last_d = sel_idx;
            idx_d  = sel_idx;
            dend_d = sel_dend;
            dsor_d = sel_dsor;
            if (sel_dsor == '0) begin
              quot_d  = '1;
              rem_d   = '0;
              dz_d    = 1'b1;
              err_d   = 1'b0;
              state_d = S_RESP;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          wcnt_d  = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (!DIV_BUSY) begin
            quot_d  = DIV_QUOT;
            rem_d   = DIV_REM;
            dz_d    = 1'b0;
            err_d   = 1'b0;
            state_d = S_RESP;
          end else if (wcnt_q == WAIT_LIMIT) begin
            quot_d  = '0;
            rem_d   = '0;
            dz_d    = 1'b0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      idx_q   <= '0;
      dend_q  <= '0;
      dsor_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      dend_q  <= dend_d;
      dsor_q  <= dsor_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule
